// File: rtl/bus_mem_responder_if.sv
// Tagged 64-bit request/response bus between the fetch-side initiator and a memory responder.
// Latency: none (wires only).
// Backpressure: the initiator stalls response beats with respack; requests are held until reqack.
//
// Signals:
//   reqcyc/req/reqtag   initiator -> responder  request valid, byte address, opaque tag
//   reqack              responder -> initiator  one-cycle request-accepted pulse
//   respcyc/resp/resptag responder -> initiator beat valid, beat data, tag of burst
//   respack             initiator -> responder  beat consumed
interface bus_mem_responder_if #(
   parameter int DATA_W = 64,
   parameter int TAG_W  = 13
);
   logic              reqcyc;
   logic [DATA_W-1:0] req;
   logic [TAG_W-1:0]  reqtag;
   logic              reqack;
   logic              respcyc;
   logic [DATA_W-1:0] resp;
   logic [TAG_W-1:0]  resptag;
   logic              respack;

   modport master (
      output reqcyc, req, reqtag, respack,
      input  reqack, respcyc, resp, resptag
   );

   modport slave (
      input  reqcyc, req, reqtag, respack,
      output reqack, respcyc, resp, resptag
   );
endinterface

// File: rtl/bus_mem_responder.sv
// Memory responder: one read at a time, returns a critical-word-first wrapped burst from an internal array.
// Latency: first beat valid READ_LATENCY cycles after the accepting edge; then one beat per acked cycle.
// Backpressure: bus_respack low holds the current beat (data and tag stable); requests are ignored until IDLE.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   bus (slave modport)   request/response bus (reqcyc, req, reqtag, reqack, respcyc, resp, resptag, respack)
//   ld_en, ld_addr, ld_data  preload write port into the backing array (any state)
module bus_mem_responder #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int BURST_BEATS    = 8,
   parameter int MEM_WORDS      = 4096,
   parameter int READ_LATENCY   = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   bus_mem_responder_if.slave            bus,
   input  logic                          ld_en,
   input  logic [$clog2(MEM_WORDS)-1:0]  ld_addr,
   input  logic [BUS_DATA_WIDTH-1:0]     ld_data
);

   // MEM_WORDS is assumed strictly larger than BURST_BEATS so a line index has upper bits.
   localparam int BB_W = $clog2(BURST_BEATS);
   localparam int MW_W = $clog2(MEM_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                     state, state_nxt;
   logic [7:0]                 wait_cnt, wait_nxt;
   logic [BB_W-1:0]            beat_cnt, beat_nxt;
   logic [MW_W-1:0]            word_q, word_nxt;
   logic                       reqack_q, reqack_nxt;
   logic                       respcyc_q, respcyc_nxt;
   logic [BUS_DATA_WIDTH-1:0]  resp_q, resp_nxt;
   logic [BUS_TAG_WIDTH-1:0]   tag_q, tag_nxt;

   logic [BB_W-1:0]            beat_sel;
   logic [BB_W-1:0]            rd_lo;
   logic [MW_W-1:0]            rd_idx;
   logic [BUS_DATA_WIDTH-1:0]  rd_data;

   logic [BUS_DATA_WIDTH-1:0]  mem [MEM_WORDS];

   // Only the word index bits inside the array range matter; byte offset and
   // bits above the array size are dropped on purpose.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.req[BUS_DATA_WIDTH-1:MW_W+3], bus.req[2:0]};

   // Backing array: no reset, contents survive reset. A read in the same
   // cycle as a write to that word sees the old value.
   always_ff @(posedge clk) begin
      if (ld_en) begin
         mem[ld_addr] <= ld_data;
      end
   end

   // Beat being loaded this edge: beat 0 when leaving WAIT, beat_cnt+1 in RESP.
   // Adding within BB_W bits wraps inside the line (critical word first).
   always_comb begin
      beat_sel = (state == RESP) ? beat_cnt + BB_W'(1) : '0;
      rd_lo    = word_q[BB_W-1:0] + beat_sel;
      rd_idx   = {word_q[MW_W-1:BB_W], rd_lo};
      rd_data  = mem[rd_idx];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         beat_cnt  <= '0;
         word_q    <= '0;
         reqack_q  <= 1'b0;
         respcyc_q <= 1'b0;
         resp_q    <= '0;
         tag_q     <= '0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_nxt;
         beat_cnt  <= beat_nxt;
         word_q    <= word_nxt;
         reqack_q  <= reqack_nxt;
         respcyc_q <= respcyc_nxt;
         resp_q    <= resp_nxt;
         tag_q     <= tag_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      wait_nxt    = wait_cnt;
      beat_nxt    = beat_cnt;
      word_nxt    = word_q;
      reqack_nxt  = 1'b0;
      respcyc_nxt = respcyc_q;
      resp_nxt    = resp_q;
      tag_nxt     = tag_q;

      case (state)
         IDLE: begin
            if (bus.reqcyc) begin
               state_nxt  = WAIT;
               word_nxt   = bus.req[MW_W+2:3];
               tag_nxt    = bus.reqtag;
               wait_nxt   = 8'(READ_LATENCY);
               reqack_nxt = 1'b1;
            end
         end
         WAIT: begin
            // Requests are not looked at here; the initiator holds off until reqack.
            if (wait_cnt <= 8'd1) begin
               state_nxt   = RESP;
               wait_nxt    = '0;
               beat_nxt    = '0;
               respcyc_nxt = 1'b1;
               resp_nxt    = rd_data;
            end else begin
               wait_nxt = wait_cnt - 8'd1;
            end
         end
         RESP: begin
            if (bus.respack) begin
               if (beat_cnt == BB_W'(BURST_BEATS - 1)) begin
                  state_nxt   = IDLE;
                  respcyc_nxt = 1'b0;
                  beat_nxt    = '0;
               end else begin
                  beat_nxt = beat_cnt + BB_W'(1);
                  resp_nxt = rd_data;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.reqack  = reqack_q;
   assign bus.respcyc = respcyc_q;
   assign bus.resp    = resp_q;
   assign bus.resptag = tag_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
module tb_bus_mem_responder;

   localparam int MW = 4096;
   localparam int BB = 8;
   localparam int RL = 4;

   typedef struct packed {
      logic [12:0] tag;
      logic [63:0] dat;
   } beat_t;

   logic        clk;
   logic        reset;
   logic        clk_en;
   logic        ld_en;
   logic [11:0] ld_addr;
   logic [63:0] ld_data;

   bus_mem_responder_if #(.DATA_W(64), .TAG_W(13)) bus_if ();

   bus_mem_responder #(
      .BUS_DATA_WIDTH(64),
      .BUS_TAG_WIDTH (13),
      .BURST_BEATS   (BB),
      .MEM_WORDS     (MW),
      .READ_LATENCY  (RL)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus_if),
      .ld_en  (ld_en),
      .ld_addr(ld_addr),
      .ld_data(ld_data)
   );

   int          errors = 0;
   int          checks = 0;
   int          mon_beats = 0;
   logic [63:0] ref_mem [MW];
   beat_t       exp_q [$];
   beat_t       mon_e;
   bit          held_vld = 0;
   logic [63:0] held_dat;
   logic [12:0] held_tag;

   initial begin
      clk = 1'b0;
      wait (clk_en);
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference addressing: wrap inside the line, then fold into the array.
   function automatic int beat_idx(input logic [63:0] addr, input int i);
      logic [63:0] w;
      logic [63:0] b;
      w = addr >> 3;
      b = w & ~64'(BB - 1);
      return int'((b | ((w + 64'(i)) % BB)) % MW);
   endfunction

   // Monitor: consumes one expected beat per transfer, and checks that a
   // stalled beat is still presented unchanged one cycle later.
   always @(negedge clk) begin
      if (reset) begin
         held_vld = 0;
      end else begin
         if (held_vld) begin
            chk("hold_valid", 64'(bus_if.respcyc), 64'd1);
            chk("hold_data", bus_if.resp, held_dat);
            chk("hold_tag", 64'(bus_if.resptag), 64'(held_tag));
         end
         held_vld = 0;
         if (bus_if.respcyc) begin
            if (bus_if.respack) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got data 0x%0h with no beat outstanding", bus_if.resp);
               end else begin
                  mon_e = exp_q.pop_front();
                  chk("beat_data", bus_if.resp, mon_e.dat);
                  chk("beat_tag", 64'(bus_if.resptag), 64'(mon_e.tag));
               end
               mon_beats++;
            end else begin
               held_vld = 1;
               held_dat = bus_if.resp;
               held_tag = bus_if.resptag;
            end
         end
      end
   end

   // mode: 0 respack always 1, 1 pattern 1,0,0,..., 2 random.
   // noisy: keep reqcyc high with junk during WAIT.
   // coll: write coll_dat to the beat-2 word on the edge that loads beat 2.
   // abort_at: assert reset once this many beats have transferred (0 = never).
   task automatic burst(input logic [63:0] addr, input logic [12:0] tag, input int mode,
                        input bit noisy, input bit coll, input logic [63:0] coll_dat,
                        input int abort_at);
      beat_t b;
      int    xfers = 0;
      int    j = 0;
      int    guard = 0;
      bit    r;
      bit    aborted = 0;
      for (int i = 0; i < BB; i++) begin
         b.tag = tag;
         b.dat = ref_mem[beat_idx(addr, i)];
         exp_q.push_back(b);
      end
      mon_beats = 0;
      bus_if.reqcyc = 1'b1;
      bus_if.req    = addr;
      bus_if.reqtag = tag;
      @(posedge clk); #1;
      bus_if.reqcyc = 1'b0;
      chk("reqack_pulse", 64'(bus_if.reqack), 64'd1);
      for (int c = 1; c <= RL; c++) begin
         bus_if.respack = 1'($urandom_range(0, 1));
         if (noisy && c < RL) begin
            bus_if.reqcyc = 1'b1;
            bus_if.req    = {$urandom, $urandom};
            bus_if.reqtag = 13'($urandom);
         end else begin
            bus_if.reqcyc = 1'b0;
         end
         @(posedge clk); #1;
         chk("first_beat_latency", 64'(bus_if.respcyc), 64'(c == RL));
         chk("reqack_single", 64'(bus_if.reqack), 64'd0);
      end
      bus_if.reqcyc = 1'b0;
      while (xfers < BB && guard < 200) begin
         case (mode)
            0:       r = 1'b1;
            1:       r = (j % 3 == 0);
            default: r = 1'($urandom_range(0, 1));
         endcase
         if (abort_at > 0 && xfers == abort_at) begin
            #1 reset = 1'b1;
            #1;
            chk("abort_respcyc", 64'(bus_if.respcyc), 64'd0);
            chk("abort_resp", bus_if.resp, 64'd0);
            chk("abort_resptag", 64'(bus_if.resptag), 64'd0);
            chk("abort_reqack", 64'(bus_if.reqack), 64'd0);
            exp_q.delete();
            held_vld = 0;
            #1 reset = 1'b0;
            aborted = 1;
            break;
         end
         bus_if.respack = r;
         if (coll && xfers == 1 && r) begin
            ld_en   = 1'b1;
            ld_addr = 12'(beat_idx(addr, 2));
            ld_data = coll_dat;
         end
         @(posedge clk); #1;
         if (ld_en) begin
            ref_mem[ld_addr] = ld_data;
            ld_en = 1'b0;
         end
         if (r) xfers++;
         j++;
         guard++;
      end
      if (guard >= 200) begin
         checks++;
         errors++;
         $display("FAIL burst_timeout: got %0d beats acked expected %0d", xfers, BB);
      end
      if (!aborted) begin
         chk("burst_end_respcyc", 64'(bus_if.respcyc), 64'd0);
         chk("beat_count", 64'(mon_beats), 64'(BB));
         chk("queue_drained", 64'(exp_q.size()), 64'd0);
      end
      bus_if.respack = 1'b0;
   endtask

   initial begin
      clk_en         = 1'b0;
      reset          = 1'b0;
      ld_en          = 1'b0;
      ld_addr        = '0;
      ld_data        = '0;
      bus_if.reqcyc  = 1'b0;
      bus_if.req     = '0;
      bus_if.reqtag  = '0;
      bus_if.respack = 1'b0;

      // Reset with no clock running: outputs must clear asynchronously.
      #2 reset = 1'b1;
      #1;
      chk("rst_reqack", 64'(bus_if.reqack), 64'd0);
      chk("rst_respcyc", 64'(bus_if.respcyc), 64'd0);
      chk("rst_resp", bus_if.resp, 64'd0);
      chk("rst_resptag", 64'(bus_if.resptag), 64'd0);
      clk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("idle_reqack", 64'(bus_if.reqack), 64'd0);
         chk("idle_respcyc", 64'(bus_if.respcyc), 64'd0);
      end

      // Preload: low line pair holds 0x1000+k, the rest random.
      for (int k = 0; k < MW; k++) begin
         ld_en   = 1'b1;
         ld_addr = 12'(k);
         ld_data = (k < 16) ? 64'h1000 + 64'(k) : {$urandom, $urandom};
         ref_mem[k] = ld_data;
         @(posedge clk); #1;
      end
      ld_en = 1'b0;

      burst(64'h0,  13'h005,  0, 0, 0, 64'h0, 0);   // aligned
      burst(64'h28, 13'h1ABC, 0, 0, 0, 64'h0, 0);   // critical word first
      burst(64'h80, 13'h033,  1, 0, 0, 64'h0, 0);   // backpressure 1,0,0,...
      burst(64'h0,  13'h007,  0, 0, 0, 64'h0, 4);   // reset mid-burst
      burst(64'h40, 13'h009,  0, 0, 0, 64'h0, 0);   // clean burst after reset
      burst(64'(MW) * 8, 13'h001, 0, 0, 1, 64'hDEAD_BEEF_0000_0002, 0); // wrap + collision
      burst(64'(MW) * 8, 13'h002, 0, 0, 0, 64'h0, 0); // re-read sees new word
      burst(64'h1234_5678_9ABC_DEF7, 13'h0F0, 2, 1, 0, 64'h0, 0); // noisy reqcyc in WAIT

      for (int n = 0; n < 24; n++) begin
         int gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            bus_if.respack = 1'($urandom_range(0, 1));
            ld_en   = 1'($urandom_range(0, 1));
            ld_addr = 12'($urandom);
            ld_data = {$urandom, $urandom};
            @(posedge clk); #1;
            if (ld_en) ref_mem[ld_addr] = ld_data;
            ld_en = 1'b0;
         end
         burst({$urandom, $urandom}, 13'($urandom), $urandom_range(0, 2),
               1'($urandom_range(0, 1)), 0, 64'h0, 0);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
